// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory sequencer: state
// encoding, default widths and the wait counter width.
package dmem_access_ctrl_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 255;
   localparam int CNT_W       = 8;

   // 2'd3 is unused; the FSM treats it exactly like IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

   // A load takes priority when the decoder flags both a load and a store.
   function automatic logic is_write(input logic rd, input logic wr);
      return wr & ~rd;
   endfunction

endpackage

// File: rtl/dmem_wait_timer.sv
// Counts WAIT cycles of the current access and flags the cycle in which
// the access has to be abandoned because memory never acknowledged.
module dmem_wait_timer
   import dmem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Wait counter: cleared when an access launches, advances every WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer between the pipeline and a multi-cycle data memory.
// Launches one load/store per MEM instruction, holds the request until the
// memory acknowledges (or the wait budget runs out), captures load data and
// raises the memory-wait stall towards the hazard unit.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mem_r,
   input  logic                mem_w,
   input  logic [ADDR_W-1:0]   addr_in,
   input  logic [DATA_W-1:0]   wdata_in,
   input  logic [DATA_W/8-1:0] wmask_in,
   output logic                stall_mem,
   output logic [DATA_W-1:0]   rdata_out,
   output logic                rdata_valid,
   output logic                bus_err,
   output logic                dm_req,
   output logic                dm_we,
   output logic [ADDR_W-1:0]   dm_addr,
   output logic [DATA_W-1:0]   dm_wdata,
   output logic [DATA_W/8-1:0] dm_wmask,
   input  logic                dm_ack,
   input  logic [DATA_W-1:0]   dm_rdata
);

   dmem_state_e state;
   dmem_state_e next_state;

   logic access;
   logic launch;
   logic ack_hit;
   logic timed_out;
   logic timer_en;
   logic expire;

   assign access = mem_r | mem_w;

   dmem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (launch),
      .enable (timer_en),
      .expire (expire)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; DONE always falls back to IDLE so the held MEM
   // instruction is never launched a second time.
   always_comb begin
      next_state = IDLE;
      case (state)
         WAIT:    next_state = (dm_ack || expire) ? DONE : WAIT;
         DONE:    next_state = IDLE;
         default: next_state = access ? WAIT : IDLE;
      endcase
   end

   // Output decode: stall request plus the strobes that steer the datapath.
   // Acknowledge beats timeout when both land in the same WAIT cycle.
   always_comb begin
      stall_mem = 1'b0;
      launch    = 1'b0;
      ack_hit   = 1'b0;
      timed_out = 1'b0;
      timer_en  = 1'b0;
      case (state)
         WAIT: begin
            stall_mem = 1'b1;
            timer_en  = 1'b1;
            ack_hit   = dm_ack;
            timed_out = expire & ~dm_ack;
         end
         DONE: begin
            stall_mem = 1'b0;
         end
         default: begin
            stall_mem = access & rst_n;
            launch    = access;
         end
      endcase
   end

   // Memory request, load data capture and the sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dm_req      <= 1'b0;
         dm_we       <= 1'b0;
         dm_addr     <= '0;
         dm_wdata    <= '0;
         dm_wmask    <= '0;
         rdata_out   <= '0;
         rdata_valid <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         if (launch) begin
            dm_req   <= 1'b1;
            dm_we    <= is_write(mem_r, mem_w);
            dm_addr  <= addr_in;
            dm_wdata <= wdata_in;
            dm_wmask <= wmask_in;
         end else if (ack_hit) begin
            dm_req      <= 1'b0;
            rdata_valid <= ~dm_we;
            if (!dm_we) begin
               rdata_out <= dm_rdata;
            end
         end else if (timed_out) begin
            dm_req      <= 1'b0;
            bus_err     <= 1'b1;
            rdata_out   <= '0;
            rdata_valid <= ~dm_we;
         end
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl with a short wait budget (TIMEOUT=4). Each
// directed access pushes its hand-computed outcome into a queue; a monitor
// pops it whenever the DUT finishes an access (dm_req falling edge).
module tb_dmem_access_ctrl;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_r;
   logic        mem_w;
   logic [31:0] addr_in;
   logic [31:0] wdata_in;
   logic [3:0]  wmask_in;
   logic        stall_mem;
   logic [31:0] rdata_out;
   logic        rdata_valid;
   logic        bus_err;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_wmask;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   typedef struct {
      int          id;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      int          req_cycles;
      int          stall_cycles;
      logic        rvalid;
      logic [31:0] rdata;
      logic        berr;
   } exp_t;

   exp_t exp_q[$];

   int check_cnt   = 0;
   int pass_cnt    = 0;
   int completions = 0;
   int spurious_rv = 0;
   int next_id     = 0;

   int          mem_lat  = 0;
   int          mem_ctr  = 0;
   logic [31:0] mem_data = 32'h0;

   logic        prev_req  = 1'b0;
   int          req_cnt   = 0;
   int          stall_cnt = 0;
   logic        stable    = 1'b1;
   logic        snap_we;
   logic [31:0] snap_addr;
   logic [31:0] snap_wdata;
   logic [3:0]  snap_mask;

   dmem_access_ctrl #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_r       (mem_r),
      .mem_w       (mem_w),
      .addr_in     (addr_in),
      .wdata_in    (wdata_in),
      .wmask_in    (wmask_in),
      .stall_mem   (stall_mem),
      .rdata_out   (rdata_out),
      .rdata_valid (rdata_valid),
      .bus_err     (bus_err),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_wmask    (dm_wmask),
      .dm_ack      (dm_ack),
      .dm_rdata    (dm_rdata)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_cnt++;
      if (actual === expected) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Memory model: acknowledges after mem_lat extra wait cycles, and shows
   // junk on the read bus whenever it is not acknowledging.
   always @(negedge clk) begin
      if (!rst_n || !dm_req) begin
         dm_ack   = 1'b0;
         dm_rdata = 32'hBAD0_BAD0;
         mem_ctr  = 0;
      end else if (mem_ctr == mem_lat) begin
         dm_ack   = 1'b1;
         dm_rdata = mem_data;
      end else begin
         dm_ack   = 1'b0;
         dm_rdata = 32'hBAD0_BAD0;
         mem_ctr++;
      end
   end

   // Monitor: tracks request burst length, stall length and bus stability,
   // and checks the queued outcome in the cycle after dm_req falls.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_req  = 1'b0;
         req_cnt   = 0;
         stall_cnt = 0;
         stable    = 1'b1;
      end else begin
         if (prev_req && !dm_req) begin
            completions++;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_completion", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput($sformatf("acc%0d_we", e.id), 32'(snap_we), 32'(e.we));
               checkOutput($sformatf("acc%0d_addr", e.id), snap_addr, e.addr);
               checkOutput($sformatf("acc%0d_wdata", e.id), snap_wdata, e.wdata);
               checkOutput($sformatf("acc%0d_mask", e.id), 32'(snap_mask), 32'(e.mask));
               checkOutput($sformatf("acc%0d_stable", e.id), 32'(stable), 32'd1);
               checkOutput($sformatf("acc%0d_req_cycles", e.id), 32'(req_cnt), 32'(e.req_cycles));
               checkOutput($sformatf("acc%0d_stall_cycles", e.id), 32'(stall_cnt), 32'(e.stall_cycles));
               checkOutput($sformatf("acc%0d_done_stall", e.id), 32'(stall_mem), 32'd0);
               checkOutput($sformatf("acc%0d_rvalid", e.id), 32'(rdata_valid), 32'(e.rvalid));
               if (e.rvalid) begin
                  checkOutput($sformatf("acc%0d_rdata", e.id), rdata_out, e.rdata);
               end
               checkOutput($sformatf("acc%0d_bus_err", e.id), 32'(bus_err), 32'(e.berr));
            end
            req_cnt   = 0;
            stall_cnt = 0;
            stable    = 1'b1;
         end else begin
            if (rdata_valid) spurious_rv++;
            if (dm_req) begin
               if (req_cnt == 0) begin
                  snap_we    = dm_we;
                  snap_addr  = dm_addr;
                  snap_wdata = dm_wdata;
                  snap_mask  = dm_wmask;
               end else if (dm_we !== snap_we || dm_addr !== snap_addr ||
                            dm_wdata !== snap_wdata || dm_wmask !== snap_mask) begin
                  stable = 1'b0;
               end
               req_cnt++;
            end
            if (stall_mem) stall_cnt++;
         end
         prev_req = dm_req;
      end
   end

   // Presents one MEM instruction and queues its hand-computed outcome.
   task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] m,
                                input int lat, input logic [31:0] rd,
                                input int exp_req, input int exp_stall,
                                input logic exp_rvalid, input logic [31:0] exp_rdata,
                                input logic exp_berr);
      exp_t e;
      mem_lat  = lat;
      mem_data = rd;
      mem_r    = r;
      mem_w    = w;
      addr_in  = a;
      wdata_in = wd;
      wmask_in = m;
      e.id           = next_id;
      e.we           = w & ~r;
      e.addr         = a;
      e.wdata        = wd;
      e.mask         = m;
      e.req_cycles   = exp_req;
      e.stall_cycles = exp_stall;
      e.rvalid       = exp_rvalid;
      e.rdata        = exp_rdata;
      e.berr         = exp_berr;
      exp_q.push_back(e);
      next_id++;
   endtask

   task automatic waitDone(input string name);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!stall_mem) begin
            done = 1'b1;
            break;
         end
      end
      checkOutput({name, "_completed"}, 32'(done), 32'd1);
      #1;
   endtask

   task automatic releaseBus();
      mem_r    = 1'b0;
      mem_w    = 1'b0;
      addr_in  = 32'h0;
      wdata_in = 32'h0;
      wmask_in = 4'h0;
   endtask

   task automatic singleAccess(input string name, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] m, input int lat,
                               input logic [31:0] rd, input int exp_req,
                               input int exp_stall, input logic exp_rvalid,
                               input logic [31:0] exp_rdata, input logic exp_berr);
      @(posedge clk);
      #1;
      applyStimulus(r, w, a, wd, m, lat, rd, exp_req, exp_stall, exp_rvalid, exp_rdata, exp_berr);
      waitDone(name);
      releaseBus();
      repeat (2) @(posedge clk);
   endtask

   // Global time limit so a stuck DUT still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      rst_n    = 1'b0;
      mem_r    = 1'b1;
      mem_w    = 1'b1;
      addr_in  = 32'hFFFF_FFFF;
      wdata_in = 32'hFFFF_FFFF;
      wmask_in = 4'hF;
      #2;
      checkOutput("reset_dm_req", 32'(dm_req), 32'd0);
      checkOutput("reset_dm_we", 32'(dm_we), 32'd0);
      checkOutput("reset_bus_err", 32'(bus_err), 32'd0);
      checkOutput("reset_rdata_valid", 32'(rdata_valid), 32'd0);
      checkOutput("reset_rdata_out", rdata_out, 32'd0);
      checkOutput("reset_dm_addr", dm_addr, 32'd0);
      checkOutput("reset_dm_wdata", dm_wdata, 32'd0);
      checkOutput("reset_dm_wmask", 32'(dm_wmask), 32'd0);
      checkOutput("reset_stall_mem", 32'(stall_mem), 32'd0);
      #10;
      releaseBus();
      #11;
      rst_n = 1'b1;

      // id, we, req cycles, stall cycles, rvalid, rdata, bus_err hand-derived for TIMEOUT=4
      singleAccess("load_zero_wait", 1, 0, 32'h100, 32'h0, 4'h0, 0, 32'hDEAD_BEEF,
                   1, 2, 1, 32'hDEAD_BEEF, 0);
      singleAccess("store_3_wait", 0, 1, 32'h204, 32'h1234_5678, 4'b0011, 3, 32'h0,
                   4, 5, 0, 32'h0, 0);
      singleAccess("load_ack_at_expiry", 1, 0, 32'h208, 32'h0, 4'h0, 3, 32'hCAFE_F00D,
                   4, 5, 1, 32'hCAFE_F00D, 0);
      singleAccess("load_1_wait", 1, 0, 32'h20C, 32'h0, 4'h0, 1, 32'h55AA_55AA,
                   2, 3, 1, 32'h55AA_55AA, 0);
      singleAccess("load_store_both", 1, 1, 32'h210, 32'hFFFF_FFFF, 4'hF, 0, 32'h1357_9BDF,
                   1, 2, 1, 32'h1357_9BDF, 0);

      // Two loads back to back with mem_r held high across DONE.
      @(posedge clk);
      #1;
      applyStimulus(1, 0, 32'h400, 32'h0, 4'h0, 0, 32'h1111_1111, 1, 2, 1, 32'h1111_1111, 0);
      waitDone("b2b_first");
      applyStimulus(1, 0, 32'h404, 32'h0, 4'h0, 0, 32'h2222_2222, 1, 2, 1, 32'h2222_2222, 0);
      waitDone("b2b_second");
      releaseBus();
      repeat (2) @(posedge clk);

      // No acknowledge: abandoned after 4 WAIT cycles, read data forced to 0.
      singleAccess("load_timeout", 1, 0, 32'h500, 32'h0, 4'h0, 1000, 32'h7777_7777,
                   4, 5, 1, 32'h0, 1);
      singleAccess("store_after_timeout", 0, 1, 32'h504, 32'hA5A5_A5A5, 4'b1100, 0, 32'h0,
                   1, 2, 0, 32'h0, 1);

      // Reset pulse in the middle of a WAIT that memory never answers.
      @(posedge clk);
      #1;
      mem_lat  = 1000;
      mem_r    = 1'b1;
      addr_in  = 32'h300;
      repeat (3) @(posedge clk);
      #3;
      checkOutput("rst_req_before", 32'(dm_req), 32'd1);
      checkOutput("rst_berr_before", 32'(bus_err), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_req_async", 32'(dm_req), 32'd0);
      checkOutput("rst_stall_async", 32'(stall_mem), 32'd0);
      checkOutput("rst_berr_async", 32'(bus_err), 32'd0);
      checkOutput("rst_addr_async", dm_addr, 32'd0);
      releaseBus();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_req_after", 32'(dm_req), 32'd0);
      checkOutput("rst_stall_after", 32'(stall_mem), 32'd0);
      checkOutput("rst_berr_after", 32'(bus_err), 32'd0);

      singleAccess("load_after_reset", 1, 0, 32'h600, 32'h0, 4'h0, 0, 32'h600D_CAFE,
                   1, 2, 1, 32'h600D_CAFE, 0);

      repeat (3) @(posedge clk);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      checkOutput("completion_count", 32'(completions), 32'd10);
      checkOutput("spurious_rdata_valid", 32'(spurious_rv), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
